// File: rtl/player_action_fsm_if.sv
// Button, hit and tick inputs plus the action outputs of one player sequencer.
// The master drives the inputs; the slave is the sequencer and drives the action outputs.
interface player_action_fsm_if;
    logic       tick;
    logic       moveBtn;
    logic       attackBtn;
    logic       defendBtn;
    logic       hitIn;
    logic [1:0] actionState;
    logic       attackReady;
    logic       stunned;
    logic       attackStart;

    modport master (
        output tick, moveBtn, attackBtn, defendBtn, hitIn,
        input  actionState, attackReady, stunned, attackStart
    );

    modport slave (
        input  tick, moveBtn, attackBtn, defendBtn, hitIn,
        output actionState, attackReady, stunned, attackStart
    );
endinterface

// File: rtl/player_action_fsm.sv
// Per-player action sequencer: attack/cooldown, time-limited defend, hit stun.
// Latency: all outputs registered, updating on the clk edge where tick is high.
// Backpressure: none; inputs are sampled every tick, and hits are latched between ticks.
module player_action_fsm #(
    parameter int ATTACK_LEN   = 8,
    parameter int COOLDOWN_LEN = 16,
    parameter int DEFEND_MAX   = 32,
    parameter int STUN_LEN     = 12,
    parameter int CNT_W        = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    player_action_fsm_if.slave  actIf
);

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_ATTACK, S_DEFEND, S_STUN} stateT;

    localparam logic [CNT_W-1:0] ATTACK_LOAD = CNT_W'(ATTACK_LEN - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_LEN);
    localparam logic [CNT_W-1:0] STUN_LOAD   = CNT_W'(STUN_LEN);
    localparam logic [CNT_W-1:0] DEFEND_LAST = CNT_W'(DEFEND_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    stateT            state, nextState;
    logic [CNT_W-1:0] actCnt, nextActCnt;
    logic [CNT_W-1:0] coolCnt, nextCoolCnt;
    logic [CNT_W-1:0] defCnt, nextDefCnt;
    logic             hitPending, nextHitPending;
    logic             defendLock, nextDefendLock;
    logic             prevAttack, nextPrevAttack;

    logic [1:0] actionStateQ, nextActionState;
    logic       attackReadyQ, nextAttackReady;
    logic       stunnedQ, nextStunned;
    logic       attackStartQ, nextAttackStart;

    logic hitNow;
    logic attackEdge;
    logic defendLimit;

    assign hitNow      = hitPending | actIf.hitIn;
    assign attackEdge  = actIf.attackBtn & ~prevAttack;
    assign defendLimit = (state == S_DEFEND) && (defCnt == DEFEND_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            actCnt       <= '0;
            coolCnt      <= '0;
            defCnt       <= '0;
            hitPending   <= 1'b0;
            defendLock   <= 1'b0;
            prevAttack   <= 1'b0;
            actionStateQ <= 2'b00;
            attackReadyQ <= 1'b1;
            stunnedQ     <= 1'b0;
            attackStartQ <= 1'b0;
        end else begin
            state        <= nextState;
            actCnt       <= nextActCnt;
            coolCnt      <= nextCoolCnt;
            defCnt       <= nextDefCnt;
            hitPending   <= nextHitPending;
            defendLock   <= nextDefendLock;
            prevAttack   <= nextPrevAttack;
            actionStateQ <= nextActionState;
            attackReadyQ <= nextAttackReady;
            stunnedQ     <= nextStunned;
            attackStartQ <= nextAttackStart;
        end
    end

    always_comb begin
        nextState      = state;
        nextActCnt     = actCnt;
        nextCoolCnt    = coolCnt;
        nextDefCnt     = defCnt;
        nextDefendLock = defendLock;
        nextPrevAttack = prevAttack;
        nextHitPending = hitPending | actIf.hitIn;

        if (actIf.tick) begin
            // Every state consumes a pending hit, so the latch always clears on a tick.
            nextHitPending = 1'b0;
            nextPrevAttack = actIf.attackBtn;
            if (coolCnt != '0) nextCoolCnt = coolCnt - CNT_ONE;
            if (!actIf.defendBtn) nextDefendLock = 1'b0;

            if (hitNow && (state != S_DEFEND)) begin
                nextState  = S_STUN;
                nextActCnt = STUN_LOAD;
                if (state == S_ATTACK) nextCoolCnt = COOL_LOAD;
            end else if (state == S_STUN) begin
                nextActCnt = actCnt - CNT_ONE;
                if (actCnt <= CNT_ONE) nextState = S_IDLE;
            end else if (state == S_ATTACK) begin
                if (actCnt == '0) begin
                    nextState   = S_IDLE;
                    nextCoolCnt = COOL_LOAD;
                end else begin
                    nextActCnt = actCnt - CNT_ONE;
                end
            end else begin
                if (state == S_DEFEND) nextDefCnt = defCnt + CNT_ONE;
                if (defendLimit && actIf.defendBtn) nextDefendLock = 1'b1;

                if (attackEdge && (coolCnt == '0)) begin
                    nextState  = S_ATTACK;
                    nextActCnt = ATTACK_LOAD;
                end else if (actIf.defendBtn && !defendLock && !defendLimit) begin
                    nextState = S_DEFEND;
                    if (state != S_DEFEND) nextDefCnt = '0;
                end else if (actIf.moveBtn) begin
                    nextState = S_MOVE;
                end else begin
                    nextState = S_IDLE;
                end
            end
        end
    end

    always_comb begin
        nextActionState = 2'b00;
        case (nextState)
            S_MOVE:   nextActionState = 2'b01;
            S_ATTACK: nextActionState = 2'b10;
            S_DEFEND: nextActionState = 2'b11;
            default:  nextActionState = 2'b00;
        endcase
        nextStunned     = (nextState == S_STUN);
        nextAttackReady = (nextCoolCnt == '0);
        // A single-clk pulse: the tick is high for one clk, so this drops on the next edge.
        nextAttackStart = actIf.tick && (nextState == S_ATTACK) && (state != S_ATTACK);
    end

    assign actIf.actionState = actionStateQ;
    assign actIf.attackReady = attackReadyQ;
    assign actIf.stunned     = stunnedQ;
    assign actIf.attackStart = attackStartQ;

endmodule

// File: doc/player_action_fsm.md
Name: player_action_fsm

Overview:
- Per-player action sequencer that turns button inputs and hit events into the 2-bit action state consumed by the one-hot state decoder directly downstream.
- Enforces attack duration and cooldown, a defend time limit with lockout, and hit stun.
- All timing advances on a game-rate tick strobe; one instance per player.

Parameters:
- ATTACK_LEN, 8, ticks an attack is held in ATTACK.
- COOLDOWN_LEN, 16, ticks after an attack ends before a new attack is accepted.
- DEFEND_MAX, 32, maximum consecutive ticks in DEFEND.
- STUN_LEN, 12, ticks of stun after an unblocked hit.
- CNT_W, 6, counter width; must hold the largest of the above.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle game-rate strobe; state, counters and edge detection advance only when high.
- moveBtn  in  1  move request (level).
- attackBtn  in  1  attack request (level; rising edge across ticks triggers).
- defendBtn  in  1  defend request (level).
- hitIn  in  1  opponent hit pulse, any cycle.
- actionState  out  2  00 IDLE, 01 MOVE, 10 ATTACK, 11 DEFEND; feeds the decoder.
- attackReady  out  1  high when cooldown is 0.
- stunned  out  1  high during stun.
- attackStart  out  1  one-cycle pulse on the tick ATTACK is entered.

Behaviour:
- Reset, asynchronous on rst_n low:
  - actionState=00, attackReady=1, stunned=0, attackStart=0.
  - All counters 0; hitPending=0; defendLock=0; prevAttack=0.
- All outputs are registered. Changes occur on the clk edge where tick=1, except the hitPending latch.
- hitPending:
  - Set on any cycle with hitIn=1.
  - Cleared on the next tick edge where it is consumed.
  - If hitIn and tick coincide, the hit is consumed on that tick.
- Attack edge: attackBtn=1 and prevAttack=0. prevAttack is updated to attackBtn on every tick.
- Internal states: IDLE, MOVE, ATTACK, DEFEND, STUN. STUN drives actionState=00 with stunned=1.
- Per-tick priority:
  1. Hit pending:
     - In DEFEND: the hit is absorbed and cleared; the state is unaffected.
     - In STUN: the stun counter reloads to STUN_LEN.
     - Otherwise: go to STUN with counter=STUN_LEN. If leaving ATTACK, the cooldown loads COOLDOWN_LEN.
  2. STUN: decrement the counter. When it reaches 0, go to IDLE on that tick, with stunned=0 on the same edge. Buttons are ignored while stunned.
  3. ATTACK: counter loaded with ATTACK_LEN-1 on entry and decremented each tick.
     - The tick on which it is 0 exits to IDLE and loads cooldown=COOLDOWN_LEN.
     - actionState=10 for exactly ATTACK_LEN ticks.
     - Buttons are ignored during ATTACK.
  4. IDLE / MOVE / DEFEND evaluation, in this order:
     - Attack edge and cooldown==0: go to ATTACK and pulse attackStart.
     - Else defendBtn and !defendLock: go to or stay in DEFEND.
     - Else moveBtn: go to MOVE.
     - Else IDLE.
- Defend limit:
  - The defend counter increments each tick spent in DEFEND and clears on entry.
  - On the tick it reaches DEFEND_MAX, exit DEFEND and set defendLock, then evaluate move/idle.
  - defendLock clears on the first tick with defendBtn=0.
- Cooldown:
  - Decrements each tick while nonzero, in any state, including STUN.
  - attackReady = (cooldown==0), registered.
  - An attack held from before cooldown expiry does not fire; a new rising edge is required.
- Simultaneous: hit on the tick an attack would start → STUN wins, no attackStart.
- Reset mid-operation: immediate return to the reset values above, regardless of tick.

Test Plan:
- Reset, buttons low, 5 ticks → actionState=00, attackReady=1, stunned=0, attackStart=0.
- attackBtn rises before tick T0, held high → attackStart=1 for one clk at T0; actionState=10 for ticks T0..T0+7; 00 at T0+8; attackReady=0 from T0+8 until T0+24, 1 at T0+24; no second attack while held.
- defendBtn held 40 ticks → 11 for 32 ticks, then 00; stays 00 while held; release one tick, press again → 11.
- In MOVE, hitIn pulse between ticks → next tick 00 with stunned=1 for 12 ticks; moveBtn ignored; MOVE resumes on the tick after stun clears.
- In DEFEND, hitIn pulse → actionState stays 11, stunned stays 0, hitPending cleared.
- Mid-attack (tick 3), hitIn → STUN; attackReady=0 for 16 ticks from that tick; rst_n low mid-stun → all outputs reset asynchronously.
